// File: rtl/led_adc_sequencer.sv
// Alternates IR and red LED phases, firing one ADC conversion per phase and storing each result per LED.
// Latency: LED drive and adc_start are registered; the sample and its valid pulse appear the cycle after adc_done.
// Backpressure: none; a conversion still open at phase end is dropped and flagged in sticky adc_err.
// Optional feature: define LEDSEQ_ADC_TIMEOUT_EN to abort a conversion ADC_TIMEOUT cycles after adc_start.
module led_adc_sequencer #(
    parameter int TICKS_PER_PHASE = 5000,
    parameter int SETTLE_TICKS    = 1000,
    parameter int ADC_TIMEOUT     = 255
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       enable,
    output logic       LED_IR_on,
    output logic       LED_RED_on,
    output logic       phase,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic [7:0] IR_ADC_Value,
    output logic       IR_valid,
    output logic [7:0] RED_ADC_Value,
    output logic       RED_valid,
    output logic       adc_err
);

    localparam int CW = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_PHASE - 1);
    localparam logic [CW-1:0] SETTLE_AT = CW'(SETTLE_TICKS);
    // The conversion deadline is a fixed offset into the phase, so the phase counter doubles as the timeout timer.
    localparam int TMO_AT = SETTLE_TICKS + ADC_TIMEOUT;

`ifdef LEDSEQ_ADC_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          phase_nxt;
    logic          phase_end;
    logic          tmo_hit;
    logic          cap_ir;
    logic          cap_red;
    logic          err_set;

    assign phase_end = (cnt == CNT_LAST);
    assign tmo_hit   = TMO_EN && (32'(cnt) == TMO_AT);

    // Next-state, phase counter and capture/error decisions; enable low overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        cap_ir    = 1'b0;
        cap_red   = 1'b0;
        err_set   = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
        end else if (state == IDLE) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
        end else begin
            cnt_nxt = cnt + CW'(1);
            case (state)
                SETTLE: begin
                    if (cnt == SETTLE_AT) begin
                        state_nxt = CONVERT;
                    end
                end
                CONVERT: begin
                    // A strobe on the terminal cycle still belongs to the ending phase.
                    if (adc_done) begin
                        cap_ir    = !phase;
                        cap_red   = phase;
                        state_nxt = HOLD;
                    end else if (phase_end) begin
                        err_set = 1'b1;
                    end else if (tmo_hit) begin
                        err_set   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                default: ;
            endcase
            if (phase_end) begin
                state_nxt = SETTLE;
                cnt_nxt   = '0;
                phase_nxt = !phase;
            end
        end
    end

    // State, counter and all outputs registered from the next-state values so they stay consistent.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            phase         <= 1'b0;
            LED_IR_on     <= 1'b0;
            LED_RED_on    <= 1'b0;
            adc_start     <= 1'b0;
            IR_ADC_Value  <= '0;
            IR_valid      <= 1'b0;
            RED_ADC_Value <= '0;
            RED_valid     <= 1'b0;
            adc_err       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            phase      <= phase_nxt;
            LED_IR_on  <= (state_nxt != IDLE) && !phase_nxt;
            LED_RED_on <= (state_nxt != IDLE) && phase_nxt;
            adc_start  <= (state_nxt == SETTLE) && (cnt_nxt == SETTLE_AT);
            IR_valid   <= cap_ir;
            RED_valid  <= cap_red;
            if (cap_ir) begin
                IR_ADC_Value <= adc_data;
            end
            if (cap_red) begin
                RED_ADC_Value <= adc_data;
            end
            adc_err <= adc_err | err_set;
        end
    end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Randomized bench for led_adc_sequencer against a time-index reference model.
// Model tracks cycles since run start; phase and position follow by division, conversions as an open window.
// ADC responses use a delay table covering early, mid, terminal-coincident, late and missing strobes.
module tb_led_adc_sequencer;

    localparam int TPP  = 20;
    localparam int ST   = 5;
    localparam int TMO  = 8;
    localparam int NCYC = 6000;

`ifdef LEDSEQ_ADC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       LED_IR_on;
    logic       LED_RED_on;
    logic       phase;
    logic       adc_start;
    logic [7:0] IR_ADC_Value;
    logic       IR_valid;
    logic [7:0] RED_ADC_Value;
    logic       RED_valid;
    logic       adc_err;

    always #5 CLK = ~CLK;

    led_adc_sequencer #(
        .TICKS_PER_PHASE(TPP),
        .SETTLE_TICKS   (ST),
        .ADC_TIMEOUT    (TMO)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .enable       (enable),
        .LED_IR_on    (LED_IR_on),
        .LED_RED_on   (LED_RED_on),
        .phase        (phase),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .IR_ADC_Value (IR_ADC_Value),
        .IR_valid     (IR_valid),
        .RED_ADC_Value(RED_ADC_Value),
        .RED_valid    (RED_valid),
        .adc_err      (adc_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: run flag, cycles since run start, open conversion window, stored samples.
    bit         m_run  = 1'b0;
    int         m_t    = 0;
    bit         m_open = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_ir   = '0;
    logic [7:0] m_red  = '0;
    bit         m_irv  = 1'b0;
    bit         m_redv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs that were stable before it.
    task automatic model_edge(input logic r, input logic e, input logic d, input logic [7:0] dat);
        int c;
        bit ph;
        c      = m_t % TPP;
        ph     = ((m_t / TPP) % 2) == 1;
        m_irv  = 1'b0;
        m_redv = 1'b0;
        if (!r) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_open = 1'b0;
            m_err  = 1'b0;
            m_ir   = '0;
            m_red  = '0;
        end else if (!e) begin
            m_run  = 1'b0;
            m_t    = 0;
            m_open = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_t    = 0;
            m_open = 1'b0;
        end else begin
            if (m_open && d) begin
                if (ph) begin
                    m_red  = dat;
                    m_redv = 1'b1;
                end else begin
                    m_ir  = dat;
                    m_irv = 1'b1;
                end
                m_open = 1'b0;
            end else if (m_open && (c == TPP - 1 || (TMO_ON && c == ST + TMO))) begin
                m_err  = 1'b1;
                m_open = 1'b0;
            end
            if (c == ST) begin
                m_open = 1'b1;
            end
            m_t++;
        end
    endtask

    task automatic check_outputs();
        int c;
        bit ph;
        c  = m_t % TPP;
        ph = ((m_t / TPP) % 2) == 1;
        check("led_ir",    32'(LED_IR_on),     32'(m_run && !ph));
        check("led_red",   32'(LED_RED_on),    32'(m_run && ph));
        check("phase",     32'(phase),         32'(m_run && ph));
        check("adc_start", 32'(adc_start),     32'(m_run && c == ST));
        check("ir_value",  32'(IR_ADC_Value),  32'(m_ir));
        check("ir_valid",  32'(IR_valid),      32'(m_irv));
        check("red_value", 32'(RED_ADC_Value), 32'(m_red));
        check("red_valid", 32'(RED_valid),     32'(m_redv));
        check("adc_err",   32'(adc_err),       32'(m_err));
    endtask

    initial begin
        int cd;
        int low_left;
        int delays[8];
        delays   = '{1, 3, 8, 9, 10, TPP - 1 - ST, TPP - ST, -1};
        cd       = -1;
        low_left = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        adc_done = 1'b0;
        adc_data = 8'h00;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLK);
            model_edge(rst_n, enable, adc_done, adc_data);
            #1;
            check_outputs();

            // Three reset edges at start, then rare random resets.
            rst_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 799) != 0);

            if (low_left > 0) begin
                enable = 1'b0;
                low_left--;
            end else if ($urandom_range(0, 249) == 0) begin
                enable   = 1'b0;
                low_left = $urandom_range(0, 3);
            end else begin
                enable = 1'b1;
            end

            // ADC behaviour: respond to each start after a delay drawn from the table, plus stray strobes.
            if (m_run && (m_t % TPP) == ST) begin
                cd = delays[$urandom_range(0, 7)];
            end
            adc_done = 1'b0;
            if (cd == 0) begin
                adc_done = 1'b1;
                cd       = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (!adc_done && $urandom_range(0, 39) == 0) begin
                adc_done = 1'b1;
            end
            adc_data = 8'($urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
